div_issue_stage: RTL and testbench

//  Streaming front-end for the 16-bit combinational divider (CombDivider16).

---
 rtl/div_issue_stage_pkg.sv | 8 +
 rtl/CombDivider16.sv | 26 ++
 rtl/div_result_fifo.sv | 45 ++++
 rtl/div_issue_stage.sv | 112 +++++++++++
 tb/tb_div_issue_stage.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_issue_stage_pkg.sv
// Shared widths and constants for the divider issue stage.
// Latency: n/a (constants only).
// Backpressure: n/a.
package div_issue_stage_pkg;
    localparam int DIV_WORD_WIDTH = 16;
    localparam int DIV_TAG_WIDTH  = 4;
    localparam logic [DIV_WORD_WIDTH-1:0] DIV_ZERO_QUOT = 16'hFFFF;
endpackage

// File: rtl/CombDivider16.sv
// Unsigned 16-bit combinational restoring divider.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
module CombDivider16 (
    input  logic [15:0] lop,
    input  logic [15:0] rop,
    output logic [15:0] quot,
    output logic [15:0] mod
);
    logic [16:0] rem;
    logic [15:0] q;

    always_comb begin
        rem = '0;
        q   = '0;
        for (int i = 15; i >= 0; i--) begin
            rem = {rem[15:0], lop[i]};
            if (rem >= {1'b0, rop}) begin
                rem  = rem - {1'b0, rop};
                q[i] = 1'b1;
            end
        end
        quot = q;
        mod  = rem[15:0];
    end
endmodule

// File: rtl/div_result_fifo.sv
// Synchronous result FIFO with occupancy count; head shown combinationally.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: caller must not push when full or pop when empty.
module div_result_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    // Storage is not reset, so gate the head to zero while empty.
    assign head_dat = (count == '0) ? '0 : mem[rd_ptr];
endmodule

// File: rtl/div_issue_stage.sv
// Streaming front-end: operand register -> CombDivider16 -> result FIFO.
// Latency: accept at edge E, result at FIFO head after E+1.
// Backpressure: in_ready from registers only (count + op_vld < depth); never from out_ready.
module div_issue_stage
    import div_issue_stage_pkg::*;
#(
    parameter int WORD_WIDTH = DIV_WORD_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_WIDTH  = DIV_TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_lop,
    input  logic [WORD_WIDTH-1:0] in_rop,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_quot,
    output logic [WORD_WIDTH-1:0] out_mod,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_div_zero,
    output logic                  busy,
    output logic [15:0]           done_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [WORD_WIDTH-1:0] quot;
        logic [WORD_WIDTH-1:0] mod;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  div_zero;
    } res_t;

    logic                  op_vld;
    logic [WORD_WIDTH-1:0] op_lop;
    logic [WORD_WIDTH-1:0] op_rop;
    logic [TAG_WIDTH-1:0]  op_tag;
    logic [WORD_WIDTH-1:0] div_quot;
    logic [WORD_WIDTH-1:0] div_mod;
    logic                  div_zero;
    logic                  accept;
    logic                  pop;
    logic [CW-1:0]         count;
    res_t                  push_dat;
    res_t                  head_dat;

    // The operand always drains next cycle, so it reserves a FIFO slot.
    assign in_ready = ({1'b0, count} + {{CW{1'b0}}, op_vld}) < DEPTH_LIM;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_vld <= 1'b0;
            op_lop <= '0;
            op_rop <= '0;
            op_tag <= '0;
        end else begin
            op_vld <= accept;
            if (accept) begin
                op_lop <= in_lop;
                op_rop <= in_rop;
                op_tag <= in_tag;
            end
        end
    end

    CombDivider16 u_div (
        .lop  (op_lop),
        .rop  (op_rop),
        .quot (div_quot),
        .mod  (div_mod)
    );

    assign div_zero = (op_rop == '0);

    always_comb begin
        push_dat          = '0;
        push_dat.quot     = div_zero ? DIV_ZERO_QUOT : div_quot;
        push_dat.mod      = div_zero ? op_lop : div_mod;
        push_dat.tag      = op_tag;
        push_dat.div_zero = div_zero;
    end

    div_result_fifo #(
        .WIDTH ($bits(res_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (op_vld),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count)
    );

    assign out_valid    = (count != '0);
    assign pop          = out_valid & out_ready;
    assign out_quot     = head_dat.quot;
    assign out_mod      = head_dat.mod;
    assign out_tag      = head_dat.tag;
    assign out_div_zero = head_dat.div_zero;
    assign busy         = op_vld | out_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) done_cnt <= '0;
        else if (pop) done_cnt <= done_cnt + 16'd1;
    end
endmodule

// File: tb/tb_div_issue_stage.sv
// Directed bench for div_issue_stage: latency, zero divide, backpressure, streaming, reset, counter wrap.
module tb_div_issue_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_lop;
    logic [15:0] in_rop;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_quot;
    logic [15:0] out_mod;
    logic [3:0]  out_tag;
    logic        out_div_zero;
    logic        busy;
    logic [15:0] done_cnt;

    int total = 0;
    int bad   = 0;

    logic [15:0] t3_quot [5] = '{16'd1, 16'd5, 16'd8, 16'd11, 16'd15};
    logic [15:0] t3_mod  [5] = '{16'd2, 16'd0, 16'd1, 16'd2, 16'd0};
    logic [15:0] t4_lop  [8] = '{16'd100, 16'd65535, 16'd7, 16'd1000, 16'd255, 16'd12345, 16'd0, 16'd65535};
    logic [15:0] t4_rop  [8] = '{16'd7, 16'd1, 16'd9, 16'd10, 16'd16, 16'd123, 16'd5, 16'd256};
    logic [15:0] t4_quot [8] = '{16'd14, 16'd65535, 16'd0, 16'd100, 16'd15, 16'd100, 16'd0, 16'd255};
    logic [15:0] t4_mod  [8] = '{16'd2, 16'd0, 16'd7, 16'd0, 16'd15, 16'd45, 16'd0, 16'd255};

    div_issue_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_lop       (in_lop),
        .in_rop       (in_rop),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_quot     (out_quot),
        .out_mod      (out_mod),
        .out_tag      (out_tag),
        .out_div_zero (out_div_zero),
        .busy         (busy),
        .done_cnt     (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] l, input logic [15:0] r, input logic [3:0] t);
        in_valid = 1'b1;
        in_lop   = l;
        in_rop   = r;
        in_tag   = t;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int   n;
        int   acc;
        int   pops;
        logic will_acc;
        logic will_pop;

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_lop = '0; in_rop = '0; in_tag = '0;
        #22;
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_quot", out_quot, 0);
        chk("rst_mod", out_mod, 0);
        chk("rst_tag", out_tag, 0);
        chk("rst_dz", out_div_zero, 0);
        chk("rst_done", done_cnt, 0);

        // 1: basic latency and result
        out_ready = 1'b1;
        drive(16'd45, 16'd13, 4'd1);
        tick();
        in_valid = 1'b0;
        chk("t1_vld_e", out_valid, 0);
        chk("t1_busy_e", busy, 1);
        tick();
        chk("t1_vld", out_valid, 1);
        chk("t1_quot", out_quot, 3);
        chk("t1_mod", out_mod, 6);
        chk("t1_tag", out_tag, 1);
        chk("t1_dz", out_div_zero, 0);
        tick();
        chk("t1_done", done_cnt, 1);
        chk("t1_empty", out_valid, 0);

        // 2: divide by zero override
        drive(16'd20, 16'd0, 4'd2);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t2_vld", out_valid, 1);
        chk("t2_quot", out_quot, 16'hFFFF);
        chk("t2_mod", out_mod, 20);
        chk("t2_tag", out_tag, 2);
        chk("t2_dz", out_div_zero, 1);
        tick();
        chk("t2_done", done_cnt, 2);

        // 3: backpressure with out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(16'(10 * i + 5), 16'd3, 4'(i));
            chk("t3_rdy", in_ready, 1);
            tick();
        end
        drive(16'd45, 16'd3, 4'd4);
        chk("t3_full_a", in_ready, 0);
        chk("t3_busy", busy, 1);
        tick();
        chk("t3_full_b", in_ready, 0);
        chk("t3_hold_vld", out_valid, 1);
        chk("t3_hold_tag", out_tag, 0);
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 5; c++) begin
            will_acc = in_valid & in_ready;
            if (out_valid) begin
                chk("t3_tag", out_tag, n);
                chk("t3_quot", out_quot, t3_quot[n]);
                chk("t3_mod", out_mod, t3_mod[n]);
                n++;
            end
            tick();
            if (will_acc) in_valid = 1'b0;
        end
        chk("t3_results", n, 5);
        chk("t3_done", done_cnt, 7);

        // 4: continuous stream, one per cycle
        pulse_reset();
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                drive(t4_lop[c], t4_rop[c], 4'(c + 8));
                chk("t4_rdy", in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            if (c == 1) chk("t4_lat", out_valid, 0);
            if (c >= 2) begin
                chk("t4_vld", out_valid, 1);
                chk("t4_tag", out_tag, c + 6);
                chk("t4_quot", out_quot, t4_quot[c-2]);
                chk("t4_mod", out_mod, t4_mod[c-2]);
            end
            if (c == 9) chk("t4_busy_hi", busy, 1);
            tick();
        end
        chk("t4_busy_lo", busy, 0);
        chk("t4_done", done_cnt, 8);
        chk("t4_empty", out_valid, 0);

        // 5: reset while results are buffered and operand in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(16'(i + 1), 16'd1, 4'(i));
            tick();
        end
        in_valid = 1'b0;
        chk("t5_pre_vld", out_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_vld", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done_cnt, 0);
        chk("t5_rdy", in_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("t5_stale_vld", out_valid, 0);
        chk("t5_stale_busy", busy, 0);
        out_ready = 1'b1;
        drive(16'd9, 16'd4, 4'd5);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t5_new_tag", out_tag, 5);
        chk("t5_new_quot", out_quot, 2);
        chk("t5_new_mod", out_mod, 1);
        tick();

        // 6: done_cnt wrap after 65535 pops
        pulse_reset();
        out_ready = 1'b1;
        acc = 0;
        pops = 0;
        drive(16'd0, 16'd1, 4'd0);
        for (int c = 0; c < 70000 && pops < 65535; c++) begin
            will_acc = in_valid & in_ready;
            will_pop = out_valid & out_ready;
            tick();
            if (will_acc) begin
                acc++;
                in_lop = acc[15:0];
                if (acc == 65536) in_valid = 1'b0;
            end
            if (will_pop) pops++;
        end
        out_ready = 1'b0;
        chk("t6_pops", pops, 65535);
        chk("t6_max", done_cnt, 16'hFFFF);
        out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 10 && n == 0; c++) begin
            will_pop = out_valid & out_ready;
            tick();
            if (will_pop) n = 1;
        end
        out_ready = 1'b0;
        chk("t6_popped", n, 1);
        chk("t6_wrap", done_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
